// File: rtl/mem_dump_tx.sv
// Memory readback streamer: reads a byte range from the 21-bit memory bus and
// sends each byte over an 8N1 UART line, followed by an 8-bit additive checksum.
module mem_dump_tx #(
    parameter int unsigned CLK_DIV     = 104,
    parameter int unsigned READ_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [20:0] start_adr,
    input  logic [20:0] count,
    input  logic        hold,
    output logic [20:0] adr,
    output logic        read,
    input  logic [7:0]  data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW   = 21;
    localparam int unsigned DW   = 8;
    localparam int unsigned DIVW = 16;
    localparam int unsigned RCW  = 4;
    localparam int unsigned BITW = 3;

    localparam logic [DIVW-1:0] DIV_RELOAD = DIVW'(CLK_DIV - 1);
    localparam logic [RCW-1:0]  RD_RELOAD  = RCW'(READ_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEXT,
        S_READ,
        S_TXSTART,
        S_TXDATA,
        S_TXSTOP,
        S_SUM,
        S_FIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_remaining;
    logic [DW-1:0]   r_sum;
    logic [DW-1:0]   r_shift;
    logic [DIVW-1:0] r_div;
    logic [BITW-1:0] r_bit;
    logic [RCW-1:0]  r_rd_cnt;
    logic            r_last;

    logic w_div_end;
    logic w_rd_end;
    logic w_read_nxt;
    logic w_tx_nxt;
    logic w_busy_nxt;
    logic w_done_nxt;

    assign w_div_end = (r_div == '0);
    assign w_rd_end  = (r_rd_cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (r_remaining == '0) w_state_nxt = S_SUM;
                else if (!hold)        w_state_nxt = S_READ;
            end
            S_READ: begin
                if (w_rd_end) w_state_nxt = S_TXSTART;
            end
            S_TXSTART: begin
                if (w_div_end) w_state_nxt = S_TXDATA;
            end
            S_TXDATA: begin
                if (w_div_end && (r_bit == BITW'(7))) w_state_nxt = S_TXSTOP;
            end
            S_TXSTOP: begin
                if (w_div_end) w_state_nxt = r_last ? S_FIN : S_NEXT;
            end
            S_SUM:   w_state_nxt = S_TXSTART;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from the next state
    always_comb begin
        w_read_nxt = (w_state_nxt == S_READ);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_FIN);
        w_tx_nxt   = 1'b1;
        case (w_state_nxt)
            S_TXSTART: w_tx_nxt = 1'b0;
            // shift advances on the bit boundary, so look one bit ahead there
            S_TXDATA:  w_tx_nxt = ((r_state == S_TXDATA) && w_div_end) ? r_shift[1] : r_shift[0];
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            adr         <= '0;
            read        <= 1'b0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            r_remaining <= '0;
            r_sum       <= '0;
            r_shift     <= '0;
            r_div       <= '0;
            r_bit       <= '0;
            r_rd_cnt    <= '0;
            r_last      <= 1'b0;
        end else begin
            read <= w_read_nxt;
            tx   <= w_tx_nxt;
            busy <= w_busy_nxt;
            done <= w_done_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        adr         <= start_adr;
                        r_remaining <= count;
                        r_sum       <= '0;
                        r_last      <= 1'b0;
                    end
                end
                S_NEXT: begin
                    r_rd_cnt <= RD_RELOAD;
                end
                S_READ: begin
                    if (w_rd_end) begin
                        r_shift     <= data;
                        r_sum       <= r_sum + data;
                        r_remaining <= r_remaining - AW'(1);
                        adr         <= adr + AW'(1);
                        r_div       <= DIV_RELOAD;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - RCW'(1);
                    end
                end
                S_SUM: begin
                    r_shift <= r_sum;
                    r_last  <= 1'b1;
                    r_div   <= DIV_RELOAD;
                end
                S_TXSTART: begin
                    if (w_div_end) begin
                        r_div <= DIV_RELOAD;
                        r_bit <= '0;
                    end else begin
                        r_div <= r_div - DIVW'(1);
                    end
                end
                S_TXDATA: begin
                    if (w_div_end) begin
                        r_div   <= DIV_RELOAD;
                        r_bit   <= r_bit + BITW'(1);
                        r_shift <= {1'b0, r_shift[DW-1:1]};
                    end else begin
                        r_div <= r_div - DIVW'(1);
                    end
                end
                S_TXSTOP: begin
                    if (!w_div_end) r_div <= r_div - DIVW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx: decodes UART frames mid-bit and checks reads,
// latency, inter-frame gaps, checksum, flow control, wrap and abort behaviour.
module tb_mem_dump_tx;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned READ_CYCLES = 2;
    localparam int          NM          = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [20:0] start_adr;
    logic [20:0] count;
    logic        hold;
    logic [20:0] adr;
    logic        read;
    logic [7:0]  data;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done_cnt = 0;
    logic [20:0] rd_q[$];

    logic [20:0] m_a [NM] = '{21'h00010, 21'h00020, 21'h00021, 21'h00022, 21'h1FFFFF,
                              21'h00000, 21'h00030, 21'h00031, 21'h00040, 21'h00041};
    logic [7:0]  m_d [NM] = '{8'hA5, 8'h80, 8'h90, 8'h01, 8'h3C,
                              8'h5A, 8'hC3, 8'h7E, 8'h12, 8'h34};

    mem_dump_tx #(.CLK_DIV(CLK_DIV), .READ_CYCLES(READ_CYCLES)) dut (
        .clk(clk), .reset(reset), .start(start), .start_adr(start_adr),
        .count(count), .hold(hold), .adr(adr), .read(read), .data(data),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational memory model
    always_comb begin
        data = 8'h00;
        for (int i = 0; i < NM; i++) begin
            if (m_a[i] == adr) data = m_d[i];
        end
    end

    always @(negedge clk) begin
        if (read === 1'b1) rd_q.push_back(adr);
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [20:0] a, input logic [20:0] n);
        @(negedge clk);
        start_adr = a;
        count     = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Waits for a start bit, then samples each bit in its middle; returns at mid stop bit
    task automatic rx_frame(input string tag, output logic [7:0] b, output int t0);
        int n = 0;
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_seen"}, {31'b0, tx}, 32'd0);
        t0 = cyc;
        @(negedge clk);
        check({tag, "_start_bit"}, {31'b0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CLK_DIV) @(negedge clk);
            b[i] = tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        check({tag, "_stop_bit"}, {31'b0, tx}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int t0, t1;

        // Reset with start held high
        reset = 1'b1; start = 1'b1; start_adr = 21'h01234; count = 21'd5; hold = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_tx",   {31'b0, tx},   32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_read", {31'b0, read}, 32'd0);
        check("rst_adr",  {11'b0, adr},  32'd0);
        @(negedge clk);
        check("rst_no_accept", {31'b0, busy}, 32'd0);

        // Single byte: exact access timing then frames
        rd_q.delete(); done_cnt = 0;
        do_start(21'h00010, 21'd1);
        check("s1_busy",   {31'b0, busy}, 32'd1);
        check("s1_next_read", {31'b0, read}, 32'd0);
        @(negedge clk);
        check("s1_read0", {31'b0, read}, 32'd1);
        check("s1_adr0",  {11'b0, adr},  32'h00010);
        @(negedge clk);
        check("s1_read1", {31'b0, read}, 32'd1);
        check("s1_adr1",  {11'b0, adr},  32'h00010);
        @(negedge clk);
        check("s1_read_off", {31'b0, read}, 32'd0);
        check("s1_tx_start", {31'b0, tx},   32'd0);
        check("s1_adr_inc",  {11'b0, adr},  32'h00011);
        rx_frame("s1_f0", b, t0);
        check("s1_byte", {24'b0, b}, 32'hA5);
        rx_frame("s1_sum", b, t1);
        check("s1_sum_byte", {24'b0, b}, 32'hA5);
        check("s1_sum_gap", t1 - t0, 32'd42);
        wait_done("s1");
        check("s1_done_cnt", done_cnt, 32'd1);
        check("s1_reads", rd_q.size(), 32'd2);

        // Multi-byte with checksum wrap
        rd_q.delete();
        do_start(21'h00020, 21'd3);
        rx_frame("m_f0", b, t0);
        check("m_b0", {24'b0, b}, 32'h80);
        rx_frame("m_f1", b, t1);
        check("m_b1", {24'b0, b}, 32'h90);
        check("m_gap", t1 - t0, 32'd43);
        rx_frame("m_f2", b, t0);
        check("m_b2", {24'b0, b}, 32'h01);
        rx_frame("m_sum", b, t1);
        check("m_sum_byte", {24'b0, b}, 32'h11);
        wait_done("m");
        check("m_adr_end", {11'b0, adr}, 32'h00023);
        check("m_reads", rd_q.size(), 32'd6);

        // Address wrap
        rd_q.delete();
        do_start(21'h1FFFFF, 21'd2);
        rx_frame("w_f0", b, t0);
        check("w_b0", {24'b0, b}, 32'h3C);
        rx_frame("w_f1", b, t0);
        check("w_b1", {24'b0, b}, 32'h5A);
        rx_frame("w_sum", b, t0);
        check("w_sum_byte", {24'b0, b}, 32'h96);
        wait_done("w");
        check("w_rd_first", {11'b0, rd_q[0]}, 32'h1FFFFF);
        check("w_rd_wrap",  {11'b0, rd_q[2]}, 32'h000000);
        check("w_adr_end",  {11'b0, adr},     32'h000001);

        // Empty transfer: checksum frame only
        rd_q.delete();
        do_start(21'h00055, 21'd0);
        @(negedge clk);
        check("e_sum_tx_idle", {31'b0, tx}, 32'd1);
        @(negedge clk);
        check("e_tx_start", {31'b0, tx}, 32'd0);
        rx_frame("e_sum", b, t0);
        check("e_sum_byte", {24'b0, b}, 32'h00);
        wait_done("e");
        check("e_no_read", rd_q.size(), 32'd0);
        check("e_adr", {11'b0, adr}, 32'h00055);

        // Flow control during the first stop bit
        rd_q.delete();
        do_start(21'h00030, 21'd2);
        rx_frame("h_f0", b, t0);
        check("h_b0", {24'b0, b}, 32'hC3);
        hold = 1'b1;
        repeat (50) @(negedge clk);
        check("h_no_read", rd_q.size(), 32'd2);
        check("h_tx_idle", {31'b0, tx}, 32'd1);
        hold = 1'b0;
        @(negedge clk);
        check("h_read_release", {31'b0, read}, 32'd1);
        check("h_adr_release",  {11'b0, adr},  32'h00031);
        rx_frame("h_f1", b, t0);
        check("h_b1", {24'b0, b}, 32'h7E);
        rx_frame("h_sum", b, t0);
        check("h_sum_byte", {24'b0, b}, 32'h41);
        wait_done("h");

        // Abort: ignored start while busy, then reset mid-data
        done_cnt = 0;
        do_start(21'h00040, 21'd2);
        begin
            int n = 0;
            while (tx !== 1'b0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        start_adr = 21'h01234; count = 21'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("a_start_ignored", {11'b0, adr}, 32'h00041);
        check("a_busy", {31'b0, busy}, 32'd1);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("a_rst_tx",   {31'b0, tx},   32'd1);
        check("a_rst_busy", {31'b0, busy}, 32'd0);
        check("a_rst_adr",  {11'b0, adr},  32'd0);
        repeat (60) @(negedge clk);
        check("a_no_done", done_cnt, 32'd0);
        check("a_stay_idle", {31'b0, busy}, 32'd0);
        do_start(21'h00041, 21'd1);
        rx_frame("a_f0", b, t0);
        check("a_b0", {24'b0, b}, 32'h34);
        rx_frame("a_sum", b, t0);
        check("a_sum_byte", {24'b0, b}, 32'h34);
        wait_done("a");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_dump_tx.md
Name: mem_dump_tx

Overview:
UART transmit-side counterpart of the programming loader. The loader receives bytes over RX and writes them to the 21-bit memory bus. This block reads a range of that bus and streams the bytes out over TX (8N1), followed by an 8-bit checksum byte. Top level instantiates it on the fast clock while the CPU is held in reset, muxed onto adr/n_read the same way as the loader, for host-side readback and verification of loaded images.

Parameters:
CLK_DIV, 104, clock cycles per UART bit; legal range 2..65535.
READ_CYCLES, 2, clock cycles read is held per byte access, data sampled on the last; legal range 1..15.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
start  input  1  one-cycle request; sampled only in IDLE
start_adr  input  21  first byte address; latched on accepted start
count  input  21  number of data bytes; latched on accepted start; 0 = checksum only
hold  input  1  flow control; 1 = do not begin the next byte read
adr  output  21  memory address
read  output  1  memory read strobe, active-high
data  input  8  memory read data
tx  output  1  UART line, idle high
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at end of transfer

Behaviour:
- Reset, and the cycle after any cycle with reset=1: adr=0, read=0, tx=1, busy=0, done=0, state=IDLE, checksum=0. Reset mid-operation aborts immediately and may truncate a frame; tx is forced high.
- States: IDLE, NEXT, READ, TXSTART, TXDATA, TXSTOP, SUM, FIN.
- IDLE: when start=1, latch start_adr into adr and count into remaining, clear checksum, set busy=1, then go to NEXT. start is ignored in every other state.
- NEXT: if remaining=0, go to SUM. Else if hold=1, stay. Else go to READ with read=1.
- READ: read=1 and adr stable for exactly READ_CYCLES cycles. On the edge ending the last cycle:
  - capture data into the shift register;
  - checksum += data (mod 256);
  - remaining -= 1;
  - read=0;
  - go to TXSTART.
  - adr increments by 1 (mod 2^21, so 0x1FFFFF wraps to 0x000000) on the same edge.
- SUM: load checksum into the shift register and go to TXSTART. A flag marks this as the final frame. hold is not checked before the checksum frame.
- Frame: TXSTART drives tx=0 for CLK_DIV cycles. TXDATA sends 8 bits LSB first, each for CLK_DIV cycles. TXSTOP drives tx=1 for CLK_DIV cycles. One frame is 10*CLK_DIV cycles. Bit counter is 3 bits; divider counter is 16 bits and reloads at each bit boundary.
- After TXSTOP: go to NEXT for a data frame, or FIN for the checksum frame.
- FIN: lasts one cycle with done=1. busy=0 from the next cycle and the state returns to IDLE. A start in the cycle after FIN is accepted.
- There is no idle gap between frames beyond the NEXT cycle and the READ_CYCLES access time. Stop bit to next start bit gap is 1+READ_CYCLES cycles when hold=0.
- read is never asserted outside READ. adr holds its last value in IDLE.
- Latency, start to first start bit: start edge, 1 NEXT cycle, READ_CYCLES cycles, then tx=0.

Test Plan:
- Reset: assert reset for 2 cycles with start=1 → tx=1, busy=0, done=0, read=0, adr=0; start during reset is not accepted.
- Single byte (CLK_DIV=4, READ_CYCLES=2), start_adr=0x00010, count=1, mem=0xA5 →
  - read=1 for 2 cycles at adr 0x00010;
  - tx sends 0,1,0,1,0,0,1,0,1,1 (each 4 cycles);
  - checksum frame 0xA5 follows;
  - done pulses once and busy then falls.
- Multi-byte: count=3, mem=0x80,0x90,0x01 → three frames in order, then checksum 0x11; adr ends at start_adr+3.
- Wrap/empty:
  - start_adr=0x1FFFFF, count=2 → reads at 0x1FFFFF then 0x000000.
  - count=0 → no read, single frame 0x00, done.
- Flow control: hold=1 raised during the first frame's stop bit and released 50 cycles later → no read until the cycle after release; frame contents unchanged.
- Abort: start issued while busy is ignored (adr unchanged); reset mid-TXDATA → tx=1 and busy=0 next cycle; a new start then transmits normally.
